// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_pkg
// Purpose  : Shared state encodings, command codes and sizing helper for the
//            parametrised SPI slave and its tx shifter.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        READ_DATA = 3'b001,
        READ_ADD  = 3'b011,
        CHK_CMD   = 3'b111,
        WRITE     = 3'b100
    } state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_WAIT  = 2'b01,
        TX_SHIFT = 2'b10,
        TX_DONE  = 2'b11
    } tx_state_e;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    // Width of a counter that must hold every value 0..n without wrapping.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_shifter
// Purpose  : Waits for the RAM read word, then drives it MSB-first on MISO.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module spi_tx_shifter
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              start,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso
);

    localparam int c_CNT_W = cnt_width(DATA_W);

    tx_state_e          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            miso    <= 1'b0;
        end else if (abort) begin
            // Slave deselected: drop whatever word was in flight.
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            miso    <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    miso <= 1'b0;
                    if (start) begin
                        r_state <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    miso <= 1'b0;
                    if (tx_valid) begin
                        r_word  <= tx_data;
                        r_cnt   <= '0;
                        r_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    miso   <= r_word[DATA_W-1];
                    r_word <= {r_word[DATA_W-2:0], 1'b0};
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(DATA_W - 1)) begin
                        r_state <= TX_DONE;
                    end
                end
                TX_DONE: begin
                    miso <= 1'b0;
                end
                default: begin
                    r_state <= TX_IDLE;
                    miso    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_param
// Purpose  : Parametrised SPI slave: deserialises DATA_W+2 bit frames and
//            serialises the RAM read word on MISO after a read-data command.
//            Define SPI_SLAVE_PARITY_EN to append an even parity bit per frame.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int FRAME_W = DATA_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               rd_pending
`ifdef SPI_SLAVE_PARITY_EN
    ,
    output logic               parity_err
`endif
);

`ifdef SPI_SLAVE_PARITY_EN
    localparam int c_NBITS = FRAME_W + 1;
`else
    localparam int c_NBITS = FRAME_W;
`endif
    localparam int c_CNT_W = cnt_width(c_NBITS);

    state_e             r_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_NBITS-2:0] r_shift;

    logic [c_NBITS-1:0] w_frame;
    logic [FRAME_W-1:0] w_rx_word;
    logic               w_in_data;
    logic               w_take;
    logic               w_done;
    logic               w_par_ok;
    logic               w_accept;
    logic               w_tx_start;

    // The bit on MOSI this cycle completes the frame when it is the last one.
    assign w_frame   = {r_shift, MOSI};
    assign w_rx_word = w_frame[c_NBITS-1 -: FRAME_W];

    assign w_in_data = (r_state == WRITE) || (r_state == READ_ADD) ||
                       (r_state == READ_DATA);
    assign w_take    = w_in_data && (r_bit_cnt < c_CNT_W'(c_NBITS));
    assign w_done    = w_take && (r_bit_cnt == c_CNT_W'(c_NBITS - 1));

`ifdef SPI_SLAVE_PARITY_EN
    assign w_par_ok  = ~(^w_frame);
`else
    assign w_par_ok  = 1'b1;
`endif

    assign w_accept   = w_done && w_par_ok;
    assign w_tx_start = w_accept && (r_state == READ_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rd_pending <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
            parity_err <= w_done && !w_par_ok;
`endif
            if (w_accept) begin
                rx_data  <= w_rx_word;
                rx_valid <= 1'b1;
            end

            if (w_accept && (r_state == READ_ADD)) begin
                rd_pending <= 1'b1;
            end else if (w_accept && (r_state == READ_DATA)) begin
                rd_pending <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    if (!SS_n) begin
                        r_state <= CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    if (SS_n) begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                    end else begin
                        r_shift   <= w_frame[c_NBITS-2:0];
                        r_bit_cnt <= c_CNT_W'(1);
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (rd_pending) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (w_take) begin
                        r_shift   <= w_frame[c_NBITS-2:0];
                        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    end
                    // A last bit arriving with SS_n high still completes above.
                    if (SS_n) begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx_shifter (
        .clk      (clk),
        .rst      (rst),
        .abort    (SS_n),
        .start    (w_tx_start),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .miso     (MISO)
    );

endmodule
`default_nettype wire

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised SPI slave, the successor to the fixed 10-bit/8-bit SPI slave. It deserialises MOSI frames of DATA_W+2 bits (a 2-bit command plus a DATA_W payload) and presents each complete frame on rx_data with a one-cycle rx_valid strobe. On a read-data command it serialises the tx_data word returned by the attached RAM onto MISO, MSB first. It sits between the SPI pins and the SPI RAM in the SPI wrapper.

Parameters:
DATA_W, 8, payload and tx word width in bits (>=2).
FRAME_W, DATA_W+2, derived frame length in bits; do not override.

Ports:
clk  in  1  system/SPI clock; all sampling is on the posedge.
rst  in  1  asynchronous, active-high reset.
SS_n  in  1  slave select, active low.
MOSI  in  1  serial data in, sampled on the clk posedge.
MISO  out  1  serial data out, registered.
rx_data  out  FRAME_W  last complete frame; bits [FRAME_W-1:FRAME_W-2] are the command.
rx_valid  out  1  one-cycle strobe marking rx_data as new.
tx_data  in  DATA_W  read word from the RAM.
tx_valid  in  1  tx_data valid; sampled only in the TX_WAIT phase.
rd_pending  out  1  read address accepted, read-data frame expected (rd_flag).

Behaviour:
- Reset (rst=1, async): state IDLE; rx_data=0, rx_valid=0, MISO=0, rd_pending=0; bit counter, shift register and tx counter all 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. SS_n=1 in any state forces the next state to IDLE and clears both counters.
- IDLE -> CHK_CMD when SS_n=0.
- CHK_CMD: the MOSI sampled at the edge leaving this state is frame bit 0 (the MSB).
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_pending=0 -> READ_ADD.
  - MOSI=1 and rd_pending=1 -> READ_DATA.
- Shifting:
  - Frame bits 0..FRAME_W-1 are shifted MSB-first into an internal register, one bit per clk.
  - At the edge sampling bit FRAME_W-1, rx_data <= complete frame and rx_valid <= 1. rx_valid is high for exactly the following cycle.
  - rx_data changes only on frame completion; it holds its value otherwise.
  - After completion the slave stays in its state, ignores MOSI and issues no further rx_valid until SS_n rises.
- Short frame (SS_n rises before FRAME_W bits): no rx_valid, rx_data unchanged, rd_pending unchanged.
- rd_pending: set on frame completion in READ_ADD; cleared on frame completion in READ_DATA. No other state changes it.
- READ_DATA tx phase:
  - After frame completion the slave enters TX_WAIT. A tx sub-state lives in the tx shifter; the main state stays READ_DATA.
  - The first cycle with tx_valid=1 loads tx_data.
  - From the next edge, MISO drives tx bits DATA_W-1..0 on DATA_W successive edges. MISO then returns to 0.
  - One word is sent per frame; tx_valid is ignored after the load.
  - SS_n rising mid-transmission aborts the word: MISO=0 at the next edge.
- MISO=0 whenever the slave is not transmitting.
- Widths:
  - Bit counter is $clog2(FRAME_W+1) bits and saturates at FRAME_W.
  - Tx counter is $clog2(DATA_W+1) bits.
  - No wrap-around is permitted.
- Simultaneous events: SS_n rising on the same edge as the last frame bit completes the frame (rx_valid pulses, rd_pending updates) and then goes to IDLE.

Optional Feature:
Macro SPI_SLAVE_PARITY_EN.
- Defined:
  - Frame becomes FRAME_W+1 bits; the final bit is even parity over the preceding FRAME_W bits.
  - Adds output port parity_err (1 bit, reset 0), a one-cycle strobe on mismatch.
  - On mismatch, rx_valid is suppressed, rx_data is unchanged and rd_pending is unchanged.
  - The parity bit is not stored in rx_data.
- Not defined: no parity bit, no parity_err port; behaviour exactly as above.

Decomposition:
- Package spi_slave_pkg:
  - State encodings: IDLE=3'b000, READ_DATA=3'b001, READ_ADD=3'b011, CHK_CMD=3'b111, WRITE=3'b100.
  - Command codes: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
  - Helper function for counter widths.
- One sub-module, spi_tx_shifter, owns TX_WAIT/SHIFT/DONE, the tx counter and the MISO register.

Test Plan:
- Write-address frame 10'h0AA (DATA_W=8) -> rx_data=10'h0AA one cycle after the 10th bit; rx_valid high exactly 1 cycle; rd_pending=0.
- Read-address frame 10'h255 -> rx_valid pulse, rx_data=10'h255, rd_pending=1. A following read-data frame 10'h300 with tx_valid=1, tx_data=8'hA5 -> MISO=1,0,1,0,0,1,0,1 on consecutive edges, then 0; rd_pending=0.
- SS_n high after 5 bits of frame 10'h3FF -> no rx_valid, rx_data keeps its prior value; the next full frame is received correctly.
- rst asserted mid-MISO transmission -> MISO=0, rd_pending=0, state IDLE immediately (async); the next frame is received normally.
- DATA_W=16 instance, frame 18'h1_BEEF -> rx_data=18'h1BEEF, rx_valid 1 cycle, 18 bits counted.
- SPI_SLAVE_PARITY_EN: frame 10'h0AA with a wrong parity bit -> parity_err pulses 1 cycle, no rx_valid; with the correct parity bit -> rx_valid and rx_data=10'h0AA.
